// File: rtl/bin_frame_tx.sv
// bin_frame_tx: binary video frame transmitter.
// Pulls one bit per active pixel slot from a valid/ready source and emits a
// registered vsync/href/clken/bit stream framed as VSYNC, VBACK, ACTIVE and
// VFRONT line groups. Each line is IMG_HDISP active slots followed by H_BLANK
// slots. One slot lasts CLKEN_DIV clocks, and the slot decision is made on
// the last clock of the slot.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no frame in progress, all outputs quiet, waiting for enable
// S_VSYNC  | V_SYNC lines with vsync asserted
// S_VBACK  | V_BACK blank lines after sync
// S_ACTIVE | IMG_VDISP lines; first IMG_HDISP slots of each carry pixels
// S_VFRONT | V_FRONT blank lines; enable on the last slot chains a new frame
module bin_frame_tx #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter int          H_BLANK   = 160,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter int          V_FRONT   = 10,
    parameter int          CLKEN_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic s_valid,
    output logic s_ready,
    input  logic s_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit,
    output logic frame_done,
    output logic underrun
);

    localparam int H_TOTAL = int'(IMG_HDISP) + H_BLANK;
    localparam int V_MAX_A = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX_B = (V_FRONT > int'(IMG_VDISP)) ? V_FRONT : int'(IMG_VDISP);
    localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;

    // One extra code in the pixel counter keeps IMG_HDISP representable even
    // with no horizontal blanking.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam int DW = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(int'(IMG_HDISP));
    localparam logic [DW-1:0] D_LAST  = DW'(CLKEN_DIV - 1);
    localparam logic [VW-1:0] VS_LAST = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST = VW'(int'(IMG_VDISP) - 1);
    localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic tick;
    logic act_slot;
    logic slot_go;
    logic v_last;

    // Slot strobe, active-pixel window and last-line detect for the current state.
    always_comb begin
        tick     = (div_cnt == D_LAST);
        act_slot = (state == S_ACTIVE) && (h_cnt < H_ACT);
        slot_go  = tick && act_slot && !rst;
        s_ready  = slot_go;
        v_last   = 1'b0;
        case (state)
            S_VSYNC:  v_last = (v_cnt == VS_LAST);
            S_VBACK:  v_last = (v_cnt == VB_LAST);
            S_ACTIVE: v_last = (v_cnt == VA_LAST);
            S_VFRONT: v_last = (v_cnt == VF_LAST);
            default:  v_last = 1'b0;
        endcase
    end

    // Frame sequencer: slot divider, pixel/line counters, state and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            div_cnt          <= '0;
            h_cnt            <= '0;
            v_cnt            <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
            frame_done       <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            post_frame_vsync <= (state == S_VSYNC);
            post_frame_href  <= act_slot;
            post_frame_clken <= slot_go;
            // A stalled source still gets its clken pulse, with the bit forced low.
            post_img_Bit     <= slot_go && s_valid && s_bit;
            frame_done       <= 1'b0;

            // A fresh stall wins over the VSYNC clear.
            if (slot_go && !s_valid) begin
                underrun <= 1'b1;
            end else if (state == S_VSYNC) begin
                underrun <= 1'b0;
            end

            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state   <= S_VSYNC;
                        div_cnt <= '0;
                        h_cnt   <= '0;
                        v_cnt   <= '0;
                    end
                end
                default: begin
                    if (tick) begin
                        if (h_cnt == H_LAST) begin
                            h_cnt <= '0;
                            if (v_last) begin
                                v_cnt <= '0;
                                case (state)
                                    S_VSYNC:  state <= S_VBACK;
                                    S_VBACK:  state <= S_ACTIVE;
                                    S_ACTIVE: state <= S_VFRONT;
                                    default: begin
                                        // Last slot of VFRONT: the divider wraps to 0
                                        // on this same strobe, so a chained VSYNC
                                        // starts with a cleared divider.
                                        frame_done <= 1'b1;
                                        state      <= enable ? S_VSYNC : S_IDLE;
                                    end
                                endcase
                            end else begin
                                v_cnt <= v_cnt + 1'b1;
                            end
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_frame_tx.sv
// tb_bin_frame_tx: two instances of bin_frame_tx (slot divider 1 and 3) on a
// small 4x3 frame, checked every cycle against a frame-position model plus
// a directed table and hand-written multi-cycle sequences.
module tb_bin_frame_tx;

    localparam int HD    = 4;
    localparam int VD    = 3;
    localparam int HB    = 2;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int HT    = HD + HB;
    localparam int LINES = VS + VB + VD + VF;

    logic       clk = 1'b0;
    logic       rst, enable, s_valid, s_bit;
    logic [1:0] s_ready, vsync, href, clken, pbit, done, urun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // reference model state per instance
    bit       m_run [2] = '{1'b0, 1'b0};
    int       m_k   [2] = '{0, 0};
    bit [5:0] m_reg [2] = '{6'd0, 6'd0};

    // source helpers
    bit pat_mode  = 1'b0;
    bit pat [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int aslot     = 0;
    int drop_slot = -1;

    typedef struct {
        bit       rst;
        bit       en;
        bit [6:0] exp;
    } vec_t;

    typedef struct {
        int        period;
        int        vs_n;
        int        href_n;
        int        ck_n;
        int        bursts;
        int        bad_gap;
        bit [11:0] bits;
        bit        ur_end;
    } meas_t;

    always #5 clk = ~clk;

    bin_frame_tx #(
        .IMG_HDISP(10'd4), .IMG_VDISP(10'd3), .H_BLANK(HB),
        .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF), .CLKEN_DIV(1)
    ) u_div1 (
        .clk(clk), .rst(rst), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready[0]), .s_bit(s_bit),
        .post_frame_vsync(vsync[0]), .post_frame_href(href[0]),
        .post_frame_clken(clken[0]), .post_img_Bit(pbit[0]),
        .frame_done(done[0]), .underrun(urun[0])
    );

    bin_frame_tx #(
        .IMG_HDISP(10'd4), .IMG_VDISP(10'd3), .H_BLANK(HB),
        .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF), .CLKEN_DIV(3)
    ) u_div3 (
        .clk(clk), .rst(rst), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready[1]), .s_bit(s_bit),
        .post_frame_vsync(vsync[1]), .post_frame_href(href[1]),
        .post_frame_clken(clken[1]), .post_img_Bit(pbit[1]),
        .frame_done(done[1]), .underrun(urun[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int frame_len(input int div);
        return LINES * HT * div;
    endfunction

    // {vsync line, active pixel, slot strobe, last clock of frame} for clock k of a frame
    function automatic logic [3:0] classify(input int k, input int div);
        int   slot, line, col;
        logic vs_l, act_l, tick_l, last_l;
        slot   = k / div;
        line   = slot / HT;
        col    = slot % HT;
        vs_l   = (line < VS);
        act_l  = (line >= VS + VB) && (line < VS + VB + VD) && (col < HD);
        tick_l = ((k % div) == div - 1);
        last_l = (k == frame_len(div) - 1);
        return {vs_l, act_l, tick_l, last_l};
    endfunction

    function automatic bit [6:0] pack(input int i);
        return {vsync[i], href[i], clken[i], pbit[i], done[i], urun[i], s_ready[i]};
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // advance the model across one clock edge using the pre-edge inputs
    task automatic model_update(input int i);
        logic [3:0] c;
        bit         rdy, ur;
        int         div;
        div = div_of(i);
        if (rst) begin
            m_run[i] = 1'b0;
            m_k[i]   = 0;
            m_reg[i] = '0;
        end else begin
            c   = classify(m_k[i], div);
            rdy = m_run[i] && c[2] && c[1];
            ur  = m_reg[i][0];
            if (rdy && !s_valid) ur = 1'b1;
            else if (m_run[i] && c[3]) ur = 1'b0;
            m_reg[i] = {m_run[i] && c[3], m_run[i] && c[2], rdy,
                        rdy && s_valid && s_bit, m_run[i] && c[0], ur};
            if (!m_run[i]) begin
                if (enable) begin
                    m_run[i] = 1'b1;
                    m_k[i]   = 0;
                end
            end else if (c[0]) begin
                if (enable) m_k[i] = 0;
                else m_run[i] = 1'b0;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end
    endtask

    task automatic check_model(input int i);
        logic [3:0] c;
        bit         exp_rdy;
        bit [6:0]   exp, got;
        c       = classify(m_k[i], div_of(i));
        exp_rdy = !rst && m_run[i] && c[2] && c[1];
        exp     = {m_reg[i], exp_rdy};
        got     = pack(i);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model_div%0d cycle %0d: got %b expected %b (vs,href,ck,bit,done,ur,rdy)",
                     div_of(i), cyc, got, exp);
        end
    endtask

    task automatic step();
        if (pat_mode) begin
            s_bit   = pat[aslot % 4];
            s_valid = !(s_ready[0] && (aslot == drop_slot));
        end
        if (s_ready[0]) aslot++;
        @(posedge clk);
        model_update(0);
        model_update(1);
        cyc++;
        @(negedge clk);
        if (rst || done[0]) aslot = 0;
        check_model(0);
        check_model(1);
    endtask

    // measure one full frame of instance i, bounded by frame_done pulses
    task automatic measure(input int i, input bit stop_en, input int drop, output meas_t m);
        int guard, last_ck, nb;
        bit prev_href;
        m     = '{default: 0};
        guard = 0;
        while (!done[i] && guard < 400) begin
            step();
            guard++;
        end
        check_int("align_frame_done", int'(done[i]), 1);
        drop_slot = drop;
        prev_href = 1'b0;
        last_ck   = -1;
        nb        = 0;
        do begin
            step();
            m.period++;
            if (stop_en && href[0]) enable = 1'b0;
            m.vs_n   += int'(vsync[i]);
            m.href_n += int'(href[i]);
            if (href[i] && !prev_href) begin
                m.bursts++;
                last_ck = -1;
            end
            if (clken[i]) begin
                if (last_ck >= 0 && (m.period - last_ck) != div_of(i)) m.bad_gap++;
                last_ck = m.period;
                if (nb < 12) m.bits[nb] = pbit[i];
                nb++;
                m.ck_n++;
            end
            prev_href = href[i];
        end while (!done[i] && m.period < 400);
        m.ur_end  = urun[i];
        drop_slot = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      tbl [11];
        meas_t     m;
        bit [11:0] exp_bits;
        bit        prev_ur;
        int        guard;

        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b1;
        s_bit   = 1'b1;

        // reset, idle, then frame start on the divide-by-1 instance
        tbl[0]  = '{1'b1, 1'b0, 7'b0000000};
        tbl[1]  = '{1'b0, 1'b0, 7'b0000000};
        tbl[2]  = '{1'b0, 1'b1, 7'b0000000};
        tbl[3]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[4]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[5]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[6]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[7]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[8]  = '{1'b0, 1'b1, 7'b1000000};
        tbl[9]  = '{1'b0, 1'b1, 7'b0000000};
        tbl[10] = '{1'b0, 1'b1, 7'b0000000};
        for (int n = 0; n < 11; n++) begin
            rst    = tbl[n].rst;
            enable = tbl[n].en;
            step();
            check_int($sformatf("table[%0d]", n), int'(pack(0)), int'(tbl[n].exp));
        end

        // basic frame and data ordering, divide-by-1
        pat      = '{1'b1, 1'b0, 1'b1, 1'b1};
        pat_mode = 1'b1;
        measure(0, 1'b0, -1, m);
        for (int n = 0; n < 12; n++) exp_bits[n] = pat[n % 4];
        check_int("d1_frame_clocks", m.period, 36);
        check_int("d1_vsync_clocks", m.vs_n, 6);
        check_int("d1_href_clocks", m.href_n, 12);
        check_int("d1_href_bursts", m.bursts, 3);
        check_int("d1_clken_pulses", m.ck_n, 12);
        check_int("d1_data_order", int'(m.bits), int'(exp_bits));
        check_int("d1_no_underrun", int'(m.ur_end), 0);

        // divide-by-3 frame
        measure(1, 1'b0, -1, m);
        check_int("d3_frame_clocks", m.period, 108);
        check_int("d3_vsync_clocks", m.vs_n, 18);
        check_int("d3_href_clocks", m.href_n, 36);
        check_int("d3_href_bursts", m.bursts, 3);
        check_int("d3_clken_pulses", m.ck_n, 12);
        check_int("d3_clken_gap_errors", m.bad_gap, 0);

        // underrun on the 2nd slot of line 2
        pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        measure(0, 1'b0, 5, m);
        check_int("ur_frame_clocks", m.period, 36);
        check_int("ur_clken_pulses", m.ck_n, 12);
        check_int("ur_href_clocks", m.href_n, 12);
        check_int("ur_pixel_bits", int'(m.bits), 12'hFDF);
        check_int("ur_sticky_at_done", int'(m.ur_end), 1);
        guard   = 0;
        prev_ur = urun[0];
        while (!vsync[0] && guard < 20) begin
            prev_ur = urun[0];
            step();
            guard++;
        end
        check_int("ur_before_vsync", int'(prev_ur), 1);
        check_int("ur_cleared_at_vsync", int'(urun[0]), 0);

        // drop enable mid-ACTIVE: frame completes, then silence
        measure(0, 1'b1, -1, m);
        check_int("stop_frame_clocks", m.period, 36);
        check_int("stop_clken_pulses", m.ck_n, 12);
        check_int("stop_href_bursts", m.bursts, 3);
        for (int n = 0; n < 40; n++) begin
            step();
            check_int($sformatf("stop_idle[%0d]", n), int'(pack(0)), 0);
        end
        enable = 1'b1;
        step();
        check_int("restart_vsync_t1", int'(vsync[0]), 0);
        step();
        check_int("restart_vsync_t2", int'(vsync[0]), 1);

        // reset mid-ACTIVE
        guard = 0;
        while (!href[0] && guard < 100) begin
            step();
            guard++;
        end
        check_int("reached_active", int'(href[0]), 1);
        rst = 1'b1;
        step();
        check_int("rst_outputs_d1", int'(pack(0)), 0);
        check_int("rst_outputs_d3", int'(pack(1)), 0);
        rst = 1'b0;
        step();
        check_int("rst_release_vsync_t1", int'(vsync[0]), 0);
        step();
        check_int("rst_release_vsync_d1", int'(vsync[0]), 1);
        check_int("rst_release_vsync_d3", int'(vsync[1]), 1);

        // randomized traffic against the model
        pat_mode = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            enable  = ($urandom_range(0, 15) != 0);
            s_valid = ($urandom_range(0, 9) != 0);
            s_bit   = $urandom_range(0, 1) == 1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_frame_tx.md
BIN_FRAME_TX -- requirements
Module: bin_frame_tx

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 10'd640, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 10'd480, meaning active lines per frame.
REQ-003 SHALL have parameters H_BLANK (160), V_SYNC (2), V_BACK (33), V_FRONT (10), CLKEN_DIV (1); H_BLANK counts pixel slots per line, the V_* parameters count whole lines, and CLKEN_DIV counts clocks per pixel slot (≥1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, a reset that is synchronous and active-high.
REQ-006 SHALL have port enable, input, 1: while high, frames are generated back-to-back.
REQ-007 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_bit (input, 1), forming the binary pixel source handshake.
REQ-008 SHALL have ports post_frame_vsync, post_frame_href, post_frame_clken and post_img_Bit, each output, 1, forming the binary video stream.
REQ-009 SHALL have port frame_done, output, 1: a one-cycle pulse at the end of each frame.
REQ-010 SHALL have port underrun, output, 1: a sticky flag for a missing source pixel.

Function
REQ-011 SHALL derive a pixel-slot strobe once every CLKEN_DIV clocks from a free-running divider; the divider is cleared on entry to VSYNC.
REQ-012 SHALL implement the FSM IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT; each line is IMG_HDISP+H_BLANK slots.
REQ-013 SHALL transition as follows:
- IDLE->VSYNC: on the first cycle enable=1.
- VSYNC->VBACK: after V_SYNC lines.
- VBACK->ACTIVE: after V_BACK lines.
- ACTIVE->VFRONT: after IMG_VDISP lines.
- VFRONT->VSYNC: after V_FRONT lines if enable=1 on the last slot; otherwise VFRONT->IDLE.
REQ-014 SHALL hold post_frame_vsync=1 exactly during VSYNC lines; it SHALL be 0 otherwise.
REQ-015 SHALL hold post_frame_href=1 during the first IMG_HDISP slots of each ACTIVE line and 0 during H_BLANK and all other states.
REQ-016 SHALL pulse post_frame_clken for one clock on each slot strobe while href=1; exactly IMG_HDISP pulses per active line.
REQ-017 SHALL assert s_ready combinationally for exactly the clock of each active-slot strobe; s_ready SHALL be 0 otherwise, irrespective of s_valid.
REQ-018 SHALL consume s_bit on a transfer (s_valid&s_ready) and present it on post_img_Bit one clock later, coincident with post_frame_clken.
REQ-019 SHALL handle a source stall (s_ready=1, s_valid=0) as follows: emit post_img_Bit=0 with clken still pulsed, set underrun=1, and leave timing unaltered.
REQ-020 SHALL keep underrun set until rst or the first clock of the next VSYNC; a new underrun in the same cycle takes priority and keeps it set.
REQ-021 SHALL register all stream outputs: vsync, href and clken align with post_img_Bit, one clock after the slot decision.
REQ-022 SHALL pulse frame_done on the clock the VFRONT last slot completes, whether the next state is VSYNC or IDLE.
REQ-023 SHALL complete the current frame when enable is deasserted mid-frame; no truncated frame is emitted.
REQ-024 SHALL size the pixel and line counters from the parameters; the counters wrap to 0 at line end and frame end with no overflow.
REQ-025 SHALL hold post_img_Bit=0 whenever post_frame_href=0.

Reset
REQ-026 SHALL apply the following on rst=1 at a clock edge: FSM=IDLE, counters=0, divider=0, and all outputs=0 (vsync, href, clken, post_img_Bit, s_ready, frame_done, underrun).
REQ-027 SHALL abort the frame immediately on reset mid-frame: outputs are 0 on the next clock, and a new frame starts from VSYNC only after rst=0 and enable=1.

Verification
REQ-028 SHALL cover the basic frame: HDISP=4, VDISP=3, H_BLANK=2, V_SYNC=V_BACK=V_FRONT=1, DIV=1, enable held, s_valid=1 -> 36-clock frame; vsync high 6 clocks; 3 href bursts of 4 clocks; 12 clken pulses; frame_done every 36 clocks.
REQ-029 SHALL cover data ordering: the source feeds the pattern 1,0,1,1 per line -> post_img_Bit reproduces 1,0,1,1 under each href burst, one clock after each s_ready transfer.
REQ-030 SHALL cover underrun: s_valid dropped on the 2nd slot of line 2 -> that pixel is 0, clken is still pulsed, underrun=1 until the next frame's VSYNC, and the timing is identical to REQ-028.
REQ-031 SHALL cover the clock divider: DIV=3 -> clken pulses spaced 3 clocks apart, href high 12 clocks per line, frame = 108 clocks.
REQ-032 SHALL cover stopping: enable dropped mid-ACTIVE -> the frame completes, frame_done pulses, FSM goes IDLE, and all outputs stay 0 until enable returns.
REQ-033 SHALL cover reset mid-frame: rst pulsed during the ACTIVE state -> all outputs 0 on the next clock; on rst release with enable=1 the next frame begins with vsync high 1 clock later.
